dio_step_sequencer: RTL and testbench

Trigger-armed pattern sequencer that drives the 8 DIO output pins of an MCC slot (Pins 1-8) from a table of up to 8 register-supplied patterns. Each pattern is held for a programmable dwell, and the table is replayed a programmable number of times. It sits between the Control register bank and OutputA[7:0], replacing ad-hoc per-pin logic. A DIO input pin or a software strobe starts a run.

---
 rtl/dio_seq_pkg.sv | 15 +
 rtl/dio_trig_sync.sv | 45 ++++
 rtl/dio_step_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_dio_step_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dio_seq_pkg.sv
// Shared types and defaults for the DIO step sequencer.
// State encoding, table geometry and counter widths live here.
package dio_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int DIO_N_STEPS = 8;
  localparam int DIO_DWELL_W = 16;
  localparam int REPEAT_W    = 8;

endpackage

// File: rtl/dio_trig_sync.sv
// Optional 2-flop synchronizer followed by a rising-edge pulse.
// SYNC=0 keeps one input register so edges still act one edge late.
module dio_trig_sync
  import dio_seq_pkg::*;
#(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic samp_q;
  logic prev_q;

  if (SYNC) begin : g_sync
    logic meta_q;
    // two-stage capture of an asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= 1'b0;
        samp_q <= 1'b0;
      end else begin
        meta_q <= din;
        samp_q <= meta_q;
      end
    end
  end else begin : g_nosync
    // single register for an already-synchronous level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) samp_q <= 1'b0;
      else     samp_q <= din;
    end
  end

  // previous sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= samp_q;
  end

  assign rise = samp_q & ~prev_q;

endmodule

// File: rtl/dio_step_sequencer.sv
// Trigger-armed pattern sequencer driving the 8 DIO output pins.
// Config is captured on arm and replayed step by step with a dwell.
module dio_step_sequencer
  import dio_seq_pkg::*;
#(
  parameter int N_STEPS = DIO_N_STEPS,
  parameter int DWELL_W = DIO_DWELL_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Arm,
  input  logic                       Abort,
  input  logic                       SwTrig,
  input  logic                       TrigPin,
  input  logic [$clog2(N_STEPS)-1:0] NumSteps,
  input  logic [REPEAT_W-1:0]        Repeat,
  input  logic [DWELL_W-1:0]         Dwell,
  input  logic [7:0]                 IdlePattern,
  input  logic [8*N_STEPS-1:0]       Patterns,
  output logic [7:0]                 DioOut,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(N_STEPS)-1:0] StepIdx
);

  localparam int STEP_W = $clog2(N_STEPS);

  logic arm_rise;
  logic sw_rise;
  logic pin_rise;
  logic trig;

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [REPEAT_W-1:0]   pass_q, pass_d;
  logic [7:0]            dio_q, dio_d;
  logic                  done_q, done_d;

  logic [STEP_W-1:0]     cfg_num_q, cfg_num_d;
  logic [REPEAT_W-1:0]   cfg_rep_q, cfg_rep_d;
  logic [DWELL_W-1:0]    cfg_dwell_q, cfg_dwell_d;
  logic [7:0]            cfg_idle_q, cfg_idle_d;
  logic [8*N_STEPS-1:0]  cfg_pat_q, cfg_pat_d;

  dio_trig_sync #(.SYNC(1'b1)) u_pin_sync (
    .clk  (Clk),
    .rst  (Reset),
    .din  (TrigPin),
    .rise (pin_rise)
  );

  dio_trig_sync #(.SYNC(1'b0)) u_sw_edge (
    .clk  (Clk),
    .rst  (Reset),
    .din  (SwTrig),
    .rise (sw_rise)
  );

  dio_trig_sync #(.SYNC(1'b0)) u_arm_edge (
    .clk  (Clk),
    .rst  (Reset),
    .din  (Arm),
    .rise (arm_rise)
  );

  assign trig = pin_rise | sw_rise;

  function automatic logic [7:0] pat_sel(
    input logic [8*N_STEPS-1:0] tbl,
    input logic [STEP_W-1:0]    idx
  );
    return tbl[int'(idx)*8 +: 8];
  endfunction

  // next-state, counters, output pattern and config capture
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    pass_d      = pass_q;
    dio_d       = dio_q;
    done_d      = 1'b0;
    cfg_num_d   = cfg_num_q;
    cfg_rep_d   = cfg_rep_q;
    cfg_dwell_d = cfg_dwell_q;
    cfg_idle_d  = cfg_idle_q;
    cfg_pat_d   = cfg_pat_q;

    if (Abort) begin
      state_d = ST_IDLE;
      step_d  = '0;
      dwell_d = '0;
      pass_d  = '0;
      dio_d   = cfg_idle_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm_rise) begin
            state_d     = ST_ARMED;
            cfg_num_d   = NumSteps;
            cfg_rep_d   = Repeat;
            cfg_dwell_d = Dwell;
            cfg_idle_d  = IdlePattern;
            cfg_pat_d   = Patterns;
            dio_d       = IdlePattern;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            state_d = ST_RUN;
            step_d  = '0;
            dwell_d = '0;
            pass_d  = REPEAT_W'(1);
            dio_d   = pat_sel(cfg_pat_q, '0);
          end
        end
        ST_RUN: begin
          if (dwell_q == cfg_dwell_q && step_q == cfg_num_q) begin
            dwell_d = '0;
            step_d  = '0;
            if (cfg_rep_q != '0 && pass_q == cfg_rep_q) begin
              state_d = ST_IDLE;
              pass_d  = '0;
              dio_d   = cfg_idle_q;
              done_d  = 1'b1;
            end else begin
              if (pass_q != '1) pass_d = pass_q + REPEAT_W'(1);
              dio_d = pat_sel(cfg_pat_q, '0);
            end
          end else if (dwell_q == cfg_dwell_q) begin
            step_d  = step_q + STEP_W'(1);
            dwell_d = '0;
            dio_d   = pat_sel(cfg_pat_q, step_q + STEP_W'(1));
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
          dwell_d = '0;
          pass_d  = '0;
          dio_d   = cfg_idle_q;
        end
      endcase
    end
  end

  // state, counters and latched configuration
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      dwell_q     <= '0;
      pass_q      <= '0;
      dio_q       <= 8'h00;
      done_q      <= 1'b0;
      cfg_num_q   <= '0;
      cfg_rep_q   <= '0;
      cfg_dwell_q <= '0;
      cfg_idle_q  <= '0;
      cfg_pat_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      pass_q      <= pass_d;
      dio_q       <= dio_d;
      done_q      <= done_d;
      cfg_num_q   <= cfg_num_d;
      cfg_rep_q   <= cfg_rep_d;
      cfg_dwell_q <= cfg_dwell_d;
      cfg_idle_q  <= cfg_idle_d;
      cfg_pat_q   <= cfg_pat_d;
    end
  end

  assign DioOut  = dio_q;
  assign Busy    = (state_q != ST_IDLE);
  assign Done    = done_q;
  assign StepIdx = step_q;

endmodule

// File: tb/tb_dio_step_sequencer.sv
// Directed bench for dio_step_sequencer.
// Expected values are hand-derived from the sequencer behaviour.
module tb_dio_step_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Arm;
  logic        Abort;
  logic        SwTrig;
  logic        TrigPin;
  logic [2:0]  NumSteps;
  logic [7:0]  Repeat;
  logic [15:0] Dwell;
  logic [7:0]  IdlePattern;
  logic [63:0] Patterns;
  logic [7:0]  DioOut;
  logic        Busy;
  logic        Done;
  logic [2:0]  StepIdx;

  int ncmp = 0;
  int nfail = 0;
  int ndone;
  logic [7:0] exp_pat;

  dio_step_sequencer #(.N_STEPS(8), .DWELL_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Arm         (Arm),
    .Abort       (Abort),
    .SwTrig      (SwTrig),
    .TrigPin     (TrigPin),
    .NumSteps    (NumSteps),
    .Repeat      (Repeat),
    .Dwell       (Dwell),
    .IdlePattern (IdlePattern),
    .Patterns    (Patterns),
    .DioOut      (DioOut),
    .Busy        (Busy),
    .Done        (Done),
    .StepIdx     (StepIdx)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm_now();
    Arm = 1'b1;
    tick(2);
    Arm = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Arm = 0; Abort = 0; SwTrig = 0; TrigPin = 0;
    NumSteps = 0; Repeat = 0; Dwell = 0; IdlePattern = 0; Patterns = 0;
    tick(2);
    Reset = 1'b0;
    tick(1);
    chk("rst_dio", DioOut, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_step", StepIdx, 3'd0);

    // basic run with config freeze
    Patterns = 64'h0000_0000_0804_0201;
    NumSteps = 3'd3; Dwell = 16'd2; Repeat = 8'd1; IdlePattern = 8'hA5;
    arm_now();
    chk("armed_busy", Busy, 1'b1);
    chk("armed_dio", DioOut, 8'hA5);
    SwTrig = 1'b1;
    tick(1);
    chk("sw_lat_busy", Busy, 1'b1);
    chk("sw_lat_dio", DioOut, 8'hA5);
    tick(1);
    SwTrig = 1'b0;
    chk("basic_c0", DioOut, 8'h01);
    chk("basic_s0", StepIdx, 3'd0);
    for (int c = 1; c < 12; c++) begin
      tick(1);
      exp_pat = 8'h01 << (c / 3);
      chk($sformatf("basic_dio_c%0d", c), DioOut, exp_pat);
      chk($sformatf("basic_step_c%0d", c), StepIdx, c / 3);
      chk($sformatf("basic_done_c%0d", c), Done, 1'b0);
      if (c == 3) begin
        Patterns = '1;
        Dwell = 16'd0;
      end
    end
    tick(1);
    chk("basic_end_dio", DioOut, 8'hA5);
    chk("basic_end_done", Done, 1'b1);
    chk("basic_end_busy", Busy, 1'b0);
    chk("basic_end_step", StepIdx, 3'd0);
    tick(1);
    chk("basic_done_pulse", Done, 1'b0);

    // pin glitch while idle is ignored
    TrigPin = 1'b1;
    tick(1);
    TrigPin = 1'b0;
    tick(4);
    chk("glitch_busy", Busy, 1'b0);

    // pin trigger latency, repeat 3
    Patterns = 64'h0000_0000_0000_2211;
    NumSteps = 3'd1; Dwell = 16'd0; Repeat = 8'd3; IdlePattern = 8'h5A;
    arm_now();
    chk("pin_armed", DioOut, 8'h5A);
    TrigPin = 1'b1;
    tick(1);
    chk("pin_k0", DioOut, 8'h5A);
    tick(1);
    chk("pin_k1", DioOut, 8'h5A);
    tick(1);
    chk("pin_k2", DioOut, 8'h11);
    ndone = 0;
    for (int c = 1; c < 6; c++) begin
      tick(1);
      exp_pat = (c % 2 == 1) ? 8'h22 : 8'h11;
      chk($sformatf("rep_dio_c%0d", c), DioOut, exp_pat);
      chk($sformatf("rep_step_c%0d", c), StepIdx, c % 2);
      if (Done) ndone++;
    end
    tick(1);
    chk("rep_end_dio", DioOut, 8'h5A);
    chk("rep_end_done", Done, 1'b1);
    chk("rep_early_done", ndone, 0);
    tick(1);
    chk("rep_busy", Busy, 1'b0);
    TrigPin = 1'b0;
    tick(3);

    // endless run until abort
    Repeat = 8'd0;
    arm_now();
    SwTrig = 1'b1;
    tick(2);
    SwTrig = 1'b0;
    chk("endless_c0", DioOut, 8'h11);
    ndone = 0;
    for (int c = 1; c <= 1100; c++) begin
      tick(1);
      if (Done) ndone++;
    end
    chk("endless_done", ndone, 0);
    chk("endless_busy", Busy, 1'b1);
    chk("endless_dio", DioOut, 8'h11);
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    chk("abort_dio", DioOut, 8'h5A);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_step", StepIdx, 3'd0);

    // abort beats a trigger in the same cycle
    IdlePattern = 8'h3C;
    arm_now();
    chk("prio_armed", DioOut, 8'h3C);
    SwTrig = 1'b1;
    tick(1);
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    chk("prio_busy", Busy, 1'b0);
    chk("prio_dio", DioOut, 8'h3C);
    tick(3);
    SwTrig = 1'b0;
    chk("prio_no_run", Busy, 1'b0);
    chk("prio_no_done", Done, 1'b0);
    tick(2);

    // async reset in the middle of a run
    Patterns = 64'h0000_0000_0804_0201;
    NumSteps = 3'd3; Dwell = 16'd2; Repeat = 8'd1;
    arm_now();
    SwTrig = 1'b1;
    tick(2);
    SwTrig = 1'b0;
    tick(4);
    chk("pre_rst_dio", DioOut, 8'h02);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_dio", DioOut, 8'h00);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_done", Done, 1'b0);
    tick(1);
    Reset = 1'b0;
    tick(2);
    chk("post_rst_dio", DioOut, 8'h00);
    chk("post_rst_done", Done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
